// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: opcode map, FSM state encoding and default widths.
package exec_pkg;

  localparam int EXEC_DEFAULT_WIDTH = 16;

  typedef logic [1:0] exec_state_t;

  localparam exec_state_t ST_IDLE = 2'd0;
  localparam exec_state_t ST_MUL  = 2'd1;
  localparam exec_state_t ST_DONE = 2'd2;

  localparam logic [7:0] OP_ADD_D   = 8'h10;
  localparam logic [7:0] OP_ADDI_D  = 8'h11;
  localparam logic [7:0] OP_AND_D   = 8'h12;
  localparam logic [7:0] OP_ANDI_D  = 8'h13;
  localparam logic [7:0] OP_MOV_D   = 8'h14;
  localparam logic [7:0] OP_MOVI_D  = 8'h15;
  localparam logic [7:0] OP_LDW_D   = 8'h20;
  localparam logic [7:0] OP_STW_D   = 8'h21;
  localparam logic [7:0] OP_BRN_D   = 8'h30;
  localparam logic [7:0] OP_BRZ_D   = 8'h31;
  localparam logic [7:0] OP_BRP_D   = 8'h32;
  localparam logic [7:0] OP_BRNZ_D  = 8'h33;
  localparam logic [7:0] OP_BRNP_D  = 8'h34;
  localparam logic [7:0] OP_BRZP_D  = 8'h35;
  localparam logic [7:0] OP_BRNZP_D = 8'h36;
  localparam logic [7:0] OP_JMP_D   = 8'h40;
  localparam logic [7:0] OP_JSR_D   = 8'h41;
  localparam logic [7:0] OP_JSRR_D  = 8'h42;
  localparam logic [7:0] OP_MUL_D   = 8'h50;
  localparam logic [7:0] OP_MULI_D  = 8'h51;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, low WIDTH bits of the product kept.
// done_o flags the cycle whose closing edge performs the final iteration.
module exec_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  assign done_o    = (cnt_q == CNT_W'(1));
  assign product_o = acc_q;

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= '0;
      cnt_q <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      if (b_q[0]) begin
        acc_q <= acc_q + a_q;
      end
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/execute_mc.sv
// Execute stage with valid/ready handshake on both sides; state updates on the falling clock edge.
// Define EXECUTE_MC_MUL_EN to build in the iterative MUL/MULI path.
//   state   | meaning
//   IDLE    | ready for a new instruction when the output slot is free
//   MUL     | multiplier iterating
//   DONE    | product ready, waiting for the output slot
module execute_mc
  import exec_pkg::*;
#(
  parameter int REG_WIDTH    = EXEC_DEFAULT_WIDTH,
  parameter int PC_WIDTH     = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int REGIDX_WIDTH = 4
) (
  input  logic                    I_CLOCK,
  input  logic                    I_RESET,
  input  logic                    I_Valid,
  output logic                    O_Ready,
  input  logic [PC_WIDTH-1:0]     I_PC,
  input  logic [OPCODE_WIDTH-1:0] I_Opcode,
  input  logic [REG_WIDTH-1:0]    I_Src1Value,
  input  logic [REG_WIDTH-1:0]    I_Src2Value,
  input  logic [REG_WIDTH-1:0]    I_Imm,
  input  logic [REG_WIDTH-1:0]    I_DestValue,
  input  logic [REGIDX_WIDTH-1:0] I_DestRegIdx,
  output logic                    O_Valid,
  input  logic                    I_Ready,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [REG_WIDTH-1:0]    O_ALUOut,
  output logic [REG_WIDTH-1:0]    O_DestValue,
  output logic [REGIDX_WIDTH-1:0] O_DestRegIdx,
  output logic                    O_Busy,
  output logic                    O_Illegal
);

  exec_state_t              state_q, state_d;
  logic                     valid_q, valid_d;
  logic                     illegal_q, illegal_d;
  logic [REG_WIDTH-1:0]     alu_q, alu_d;
  logic [REG_WIDTH-1:0]     dv_q, dv_d;
  logic [OPCODE_WIDTH-1:0]  op_q, op_d;
  logic [REGIDX_WIDTH-1:0]  idx_q, idx_d;

  logic [REG_WIDTH-1:0]     res_alu;
  logic [REGIDX_WIDTH-1:0]  res_idx;
  logic                     res_illegal;
  logic                     out_free;
  logic                     accept;
  logic                     single_accept;

  // The PC is carried for downstream stages but plays no part in the result here.
  logic unused_pc;
  assign unused_pc = ^I_PC;

  assign out_free = !valid_q || I_Ready;
  assign O_Ready  = !I_RESET && (state_q == ST_IDLE) && out_free;
  assign accept   = I_Valid && O_Ready;

`ifdef EXECUTE_MC_MUL_EN
  logic                    is_mul;
  logic                    mul_start;
  logic                    mul_done;
  logic [REG_WIDTH-1:0]    mul_b;
  logic [REG_WIDTH-1:0]    mul_product;
  logic [OPCODE_WIDTH-1:0] pend_op_q;
  logic [REGIDX_WIDTH-1:0] pend_idx_q;
  logic [REG_WIDTH-1:0]    pend_dv_q;
`endif

  always_comb begin
    res_alu     = '0;
    res_idx     = '0;
    res_illegal = 1'b0;
`ifdef EXECUTE_MC_MUL_EN
    is_mul      = 1'b0;
`endif
    case (I_Opcode)
      OP_ADD_D: begin
        res_alu = I_Src1Value + I_Src2Value;
        res_idx = I_DestRegIdx;
      end
      OP_ADDI_D: begin
        res_alu = I_Src1Value + I_Imm;
        res_idx = I_DestRegIdx;
      end
      OP_AND_D: begin
        res_alu = I_Src1Value & I_Src2Value;
        res_idx = I_DestRegIdx;
      end
      OP_ANDI_D: begin
        res_alu = I_Src1Value & I_Imm;
        res_idx = I_DestRegIdx;
      end
      OP_MOV_D: begin
        res_alu = I_Src1Value;
        res_idx = I_DestRegIdx;
      end
      OP_MOVI_D: begin
        res_alu = I_Imm;
        res_idx = I_DestRegIdx;
      end
      OP_LDW_D: begin
        res_alu = I_Src1Value + I_Imm;
        res_idx = I_DestRegIdx;
      end
      OP_STW_D: begin
        res_alu = I_Src1Value + I_Imm;
      end
      OP_BRN_D, OP_BRZ_D, OP_BRP_D, OP_BRNZ_D, OP_BRNP_D, OP_BRZP_D, OP_BRNZP_D,
      OP_JMP_D: begin
        res_alu = '0;
      end
      OP_JSR_D, OP_JSRR_D: begin
        res_alu = I_Src1Value;
        res_idx = I_DestRegIdx;
      end
`ifdef EXECUTE_MC_MUL_EN
      OP_MUL_D, OP_MULI_D: begin
        is_mul = 1'b1;
      end
`endif
      default: begin
        res_illegal = 1'b1;
      end
    endcase
  end

`ifdef EXECUTE_MC_MUL_EN
  assign single_accept = accept && !is_mul;
  assign mul_start     = accept && is_mul;
  assign mul_b         = (I_Opcode == OP_MULI_D) ? I_Imm : I_Src2Value;
  assign O_Busy        = (state_q != ST_IDLE);

  exec_mul_iter #(
    .WIDTH(REG_WIDTH)
  ) u_mul (
    .clk_i    (I_CLOCK),
    .rst_i    (I_RESET),
    .start_i  (mul_start),
    .a_i      (I_Src1Value),
    .b_i      (mul_b),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  // Instruction fields are parked here until the product reaches the output register.
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      pend_op_q  <= '0;
      pend_idx_q <= '0;
      pend_dv_q  <= '0;
    end else if (mul_start) begin
      pend_op_q  <= I_Opcode;
      pend_idx_q <= I_DestRegIdx;
      pend_dv_q  <= I_DestValue;
    end
  end
`else
  assign single_accept = accept;
  assign O_Busy        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q && !I_Ready;
    alu_d     = alu_q;
    dv_d      = dv_q;
    op_d      = op_q;
    idx_d     = idx_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (single_accept) begin
          valid_d   = 1'b1;
          alu_d     = res_alu;
          dv_d      = I_DestValue;
          op_d      = I_Opcode;
          idx_d     = res_idx;
          illegal_d = res_illegal;
        end
`ifdef EXECUTE_MC_MUL_EN
        if (mul_start) begin
          state_d = ST_MUL;
        end
`endif
      end
`ifdef EXECUTE_MC_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_free) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b1;
          alu_d     = mul_product;
          dv_d      = pend_dv_q;
          op_d      = pend_op_q;
          idx_d     = pend_idx_q;
          illegal_d = 1'b0;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      alu_q     <= '0;
      dv_q      <= '0;
      op_q      <= '0;
      idx_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      alu_q     <= alu_d;
      dv_q      <= dv_d;
      op_q      <= op_d;
      idx_q     <= idx_d;
      illegal_q <= illegal_d;
    end
  end

  assign O_Valid      = valid_q;
  assign O_ALUOut     = alu_q;
  assign O_DestValue  = dv_q;
  assign O_Opcode     = op_q;
  assign O_DestRegIdx = idx_q;
  assign O_Illegal    = illegal_q;

endmodule

// File: tb/tb_execute_mc.sv
// Randomised bench for execute_mc against a transaction-level model, plus directed literal checks.
module tb_execute_mc;
  import exec_pkg::*;

  localparam int RW = 16;
  localparam int PW = 16;
  localparam int OW = 8;
  localparam int IW = 4;
`ifdef EXECUTE_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, i_valid, i_ready;
  logic [PW-1:0] pc;
  logic [OW-1:0] op;
  logic [RW-1:0] s1, s2, imm, dv;
  logic [IW-1:0] idx;
  logic          o_ready, o_valid, o_busy, o_illegal;
  logic [OW-1:0] o_opcode;
  logic [RW-1:0] o_aluout, o_destvalue;
  logic [IW-1:0] o_destregidx;

  execute_mc #(
    .REG_WIDTH(RW), .PC_WIDTH(PW), .OPCODE_WIDTH(OW), .REGIDX_WIDTH(IW)
  ) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_Valid(i_valid), .O_Ready(o_ready),
    .I_PC(pc), .I_Opcode(op), .I_Src1Value(s1), .I_Src2Value(s2),
    .I_Imm(imm), .I_DestValue(dv), .I_DestRegIdx(idx),
    .O_Valid(o_valid), .I_Ready(i_ready), .O_Opcode(o_opcode),
    .O_ALUOut(o_aluout), .O_DestValue(o_destvalue), .O_DestRegIdx(o_destregidx),
    .O_Busy(o_busy), .O_Illegal(o_illegal)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: output slot contents plus a countdown of remaining busy cycles for a multiply.
  logic          m_valid = 1'b0, m_ill = 1'b0;
  logic [RW-1:0] m_alu = '0, m_dv = '0;
  logic [OW-1:0] m_op = '0;
  logic [IW-1:0] m_idx = '0;
  int            m_left = 0;
  logic [RW-1:0] p_alu = '0, p_dv = '0;
  logic [OW-1:0] p_op = '0;
  logic [IW-1:0] p_idx = '0;

  function automatic logic model_ready();
    return !rst && (m_left == 0) && (!m_valid || i_ready);
  endfunction

  task automatic ref_single(input logic [OW-1:0] o, input logic [RW-1:0] a, b, im,
                            input logic [IW-1:0] di, output logic [RW-1:0] r,
                            output logic [IW-1:0] ri, output logic bad);
    r = '0; ri = '0; bad = 1'b0;
    case (o)
      OP_ADD_D:  begin r = a + b;  ri = di; end
      OP_ADDI_D: begin r = a + im; ri = di; end
      OP_AND_D:  begin r = a & b;  ri = di; end
      OP_ANDI_D: begin r = a & im; ri = di; end
      OP_MOV_D:  begin r = a;      ri = di; end
      OP_MOVI_D: begin r = im;     ri = di; end
      OP_LDW_D:  begin r = a + im; ri = di; end
      OP_STW_D:  begin r = a + im; end
      OP_BRN_D, OP_BRZ_D, OP_BRP_D, OP_BRNZ_D, OP_BRNP_D, OP_BRZP_D, OP_BRNZP_D,
      OP_JMP_D:  begin r = '0; end
      OP_JSR_D, OP_JSRR_D: begin r = a; ri = di; end
      default:   bad = 1'b1;
    endcase
  endtask

  task automatic model_edge();
    logic          acc, vold;
    logic [31:0]   prod;
    logic [RW-1:0] r;
    logic [IW-1:0] ri;
    logic          bad;
    if (rst) begin
      m_valid = 1'b0; m_ill = 1'b0; m_alu = '0; m_dv = '0; m_op = '0; m_idx = '0;
      m_left = 0;
      return;
    end
    acc  = i_valid && model_ready();
    vold = m_valid;
    if (m_valid && i_ready) m_valid = 1'b0;
    if (m_left > 1) m_left--;
    else if (m_left == 1 && (!vold || i_ready)) begin
      m_valid = 1'b1; m_alu = p_alu; m_dv = p_dv; m_op = p_op; m_idx = p_idx; m_ill = 1'b0;
      m_left = 0;
    end
    if (acc) begin
      if (MUL_EN && (op == OP_MUL_D || op == OP_MULI_D)) begin
        prod   = s1 * ((op == OP_MULI_D) ? imm : s2);
        p_alu  = prod[RW-1:0];
        p_op   = op; p_idx = idx; p_dv = dv;
        m_left = RW + 1;
      end else begin
        ref_single(op, s1, s2, imm, idx, r, ri, bad);
        m_valid = 1'b1; m_alu = r; m_idx = ri; m_ill = bad; m_op = op; m_dv = dv;
      end
    end
  endtask

  task automatic compare_all();
    chk("valid",   o_valid,      m_valid);
    chk("ready",   o_ready,      model_ready());
    chk("busy",    o_busy,       m_left != 0);
    chk("aluout",  o_aluout,     m_alu);
    chk("destval", o_destvalue,  m_dv);
    chk("destidx", o_destregidx, m_idx);
    chk("opcode",  o_opcode,     m_op);
    chk("illegal", o_illegal,    m_ill);
  endtask

  // One clock cycle: drive mid-cycle, check, then advance the model at the active (falling) edge.
  task automatic cyc(input logic r, v, input logic [OW-1:0] o, input logic [RW-1:0] a, b, im, d,
                     input logic [IW-1:0] di, input logic rdy);
    @(posedge clk);
    rst = r; i_valid = v; op = o; s1 = a; s2 = b; imm = im; dv = d; idx = di; i_ready = rdy;
    pc = 16'($urandom);
    #1;
    compare_all();
    @(negedge clk);
    model_edge();
  endtask

  logic [OW-1:0] op_pool [22];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; pc = '0; op = '0;
    s1 = '0; s2 = '0; imm = '0; dv = '0; idx = '0;
    op_pool = '{OP_ADD_D, OP_ADDI_D, OP_AND_D, OP_ANDI_D, OP_MOV_D, OP_MOVI_D, OP_LDW_D,
                OP_STW_D, OP_BRN_D, OP_BRZ_D, OP_BRP_D, OP_BRNZ_D, OP_BRNP_D, OP_BRZP_D,
                OP_BRNZP_D, OP_JMP_D, OP_JSR_D, OP_JSRR_D, OP_MUL_D, OP_MULI_D,
                8'hFF, 8'h00};
    repeat (3) @(negedge clk);

    // reset holds everything cleared and refuses input
    cyc(1'b1, 1'b1, OP_ADD_D, 16'h1, 16'h2, 16'h0, 16'h0, 4'd3, 1'b1);
    #2;
    chk("rst_valid", o_valid, 32'h0);
    chk("rst_ready", o_ready, 32'h0);
    chk("rst_alu", o_aluout, 32'h0);

    // ADD overflow wraps
    cyc(1'b0, 1'b1, OP_ADD_D, 16'h7FFF, 16'h0001, 16'h0, 16'h55AA, 4'd5, 1'b1);
    #2;
    chk("add_ovf_valid", o_valid, 32'h1);
    chk("add_ovf_alu", o_aluout, 32'h8000);
    chk("add_ovf_idx", o_destregidx, 32'h5);

    // four back-to-back ADDI
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, OP_ADDI_D, 16'(i), 16'hFFFF, 16'h0010, 16'h0, 4'(i + 1), 1'b1);
      #2;
      chk("b2b_valid", o_valid, 32'h1);
      chk("b2b_alu", o_aluout, 32'h10 + i);
      chk("b2b_ready", o_ready, 32'h1);
    end

    // stall: output held, no accept until I_Ready returns
    cyc(1'b0, 1'b1, OP_ADD_D, 16'h1234, 16'h1111, 16'h0, 16'h0, 4'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, OP_MOV_D, 16'hABCD, 16'h0, 16'h0, 16'h0, 4'd7, 1'b0);
      #2;
      chk("stall_valid", o_valid, 32'h1);
      chk("stall_alu", o_aluout, 32'h2345);
      chk("stall_ready", o_ready, 32'h0);
    end
    cyc(1'b0, 1'b1, OP_MOV_D, 16'hABCD, 16'h0, 16'h0, 16'h0, 4'd7, 1'b1);
    #2;
    chk("release_alu", o_aluout, 32'hABCD);
    chk("release_idx", o_destregidx, 32'h7);

    // unknown opcode
    cyc(1'b0, 1'b1, 8'hFF, 16'h1111, 16'h2222, 16'h3333, 16'h0, 4'd9, 1'b1);
    #2;
    chk("ill_valid", o_valid, 32'h1);
    chk("ill_flag", o_illegal, 32'h1);
    chk("ill_alu", o_aluout, 32'h0);
    chk("ill_idx", o_destregidx, 32'h0);

`ifndef EXECUTE_MC_MUL_EN
    cyc(1'b0, 1'b1, OP_MUL_D, 16'h0003, 16'hFFFF, 16'h0, 16'h0, 4'd6, 1'b1);
    #2;
    chk("mul_off_valid", o_valid, 32'h1);
    chk("mul_off_ill", o_illegal, 32'h1);
    chk("mul_off_alu", o_aluout, 32'h0);
    chk("mul_off_busy", o_busy, 32'h0);
`else
    begin
      int  busy_cnt;
      logic got;
      busy_cnt = 0;
      got      = 1'b0;
      cyc(1'b0, 1'b1, OP_MUL_D, 16'h0003, 16'hFFFF, 16'h0, 16'h0, 4'd6, 1'b1);
      for (int k = 0; k < 40 && !got; k++) begin
        #2;
        if (o_valid) got = 1'b1;
        else begin
          if (o_busy) busy_cnt++;
          cyc(1'b0, 1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b1);
        end
      end
      chk("mul_seen", got, 32'h1);
      chk("mul_busy_cycles", busy_cnt, 32'd17);
      chk("mul_alu", o_aluout, 32'hFFFD);
      chk("mul_idx", o_destregidx, 32'h6);
    end
    // reset in the middle of a multiply discards it
    cyc(1'b0, 1'b1, OP_MUL_D, 16'h0005, 16'h0007, 16'h0, 16'h0, 4'd4, 1'b1);
    repeat (5) cyc(1'b0, 1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b1);
    #2;
    chk("mulrst_busy", o_busy, 32'h0);
    chk("mulrst_valid", o_valid, 32'h0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b1);
      #2;
      chk("mulrst_quiet", o_valid, 32'h0);
    end
    cyc(1'b0, 1'b1, OP_ADD_D, 16'h0002, 16'h0003, 16'h0, 16'h0, 4'd1, 1'b1);
    #2;
    chk("mulrst_add_valid", o_valid, 32'h1);
    chk("mulrst_add_alu", o_aluout, 32'h5);
`endif

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic [OW-1:0] ro;
      logic [RW-1:0] ra, rb;
      ro = op_pool[$urandom_range(0, 21)];
      if ($urandom_range(0, 15) == 0) ro = 8'($urandom);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      if ($urandom_range(0, 7) == 0) rb = 16'h8000;
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, ro, ra, rb,
          16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 16, datapath/operand width.
REQ-002 SHALL have parameter PC_WIDTH, default 16, PC width.
REQ-003 SHALL have parameter OPCODE_WIDTH, default 8, opcode width.
REQ-004 SHALL have parameter REGIDX_WIDTH, default 4, register index width.
REQ-005 SHALL use one clock and a synchronous, active-high reset; state updates on negedge I_CLOCK, as in the existing pipeline stages.
REQ-006 Ports SHALL be:
  I_CLOCK  in  1  clock.
  I_RESET  in  1  synchronous active-high reset.
  I_Valid  in  1  upstream instruction valid.
  O_Ready  out  1  stage can accept.
  I_PC  in  PC_WIDTH  instruction PC.
  I_Opcode  in  OPCODE_WIDTH  opcode.
  I_Src1Value, I_Src2Value, I_Imm, I_DestValue  in  REG_WIDTH  operands, sign-extended immediate, store data or branch target.
  I_DestRegIdx  in  REGIDX_WIDTH  destination register.
  O_Valid  out  1  result valid.
  I_Ready  in  1  memory stage accepts.
  O_Opcode  out  OPCODE_WIDTH  registered opcode.
  O_ALUOut, O_DestValue  out  REG_WIDTH  result or address; pass-through value.
  O_DestRegIdx  out  REGIDX_WIDTH  destination register.
  O_Busy  out  1  multiply in progress.
  O_Illegal  out  1  opcode unsupported; qualified by O_Valid.

Function
REQ-007 Accept SHALL occur on an edge where I_Valid && O_Ready; O_Ready = (state==IDLE) && (!O_Valid || I_Ready), combinational.
REQ-008 Output handoff SHALL occur on an edge where O_Valid && I_Ready; outputs SHALL be held stable while O_Valid && !I_Ready.
REQ-009 Single-cycle ops SHALL register results on the accept edge, so O_Valid rises one cycle after accept; back-to-back accepts SHALL sustain one instruction per cycle when I_Ready=1.
REQ-010 ADD/ADDI SHALL compute Src1+Src2 or Src1+Imm modulo 2^REG_WIDTH; AND/ANDI compute bitwise AND; MOV gives Src1; MOVI gives Imm.
REQ-011 LDW/STW SHALL give O_ALUOut=Src1+Imm modulo 2^REG_WIDTH; STW passes I_DestValue to O_DestValue.
REQ-012 BR*/JMP SHALL pass I_DestValue to O_DestValue; JSR/JSRR additionally give O_ALUOut=Src1.
REQ-013 O_DestRegIdx SHALL equal I_DestRegIdx for register-writing ops (ADD*, AND*, MOV*, LDW, JSR*, MUL*) and 0 otherwise; O_Opcode always follows I_Opcode.
REQ-014 MUL/MULI SHALL produce the low REG_WIDTH bits of Src1*Src2 or Src1*Imm using an iterative shift-add, one bit per cycle.
REQ-015 FSM SHALL have states IDLE, MUL, DONE: IDLE->MUL on a MUL accept; MUL->DONE after REG_WIDTH iterations; DONE->IDLE when the result is written to the output register (immediately if !O_Valid || I_Ready, else wait).
REQ-016 MUL latency SHALL be REG_WIDTH+1 cycles from accept to O_Valid when unstalled; O_Busy=1 in MUL and DONE.
REQ-017 An unknown opcode SHALL complete single-cycle with O_ALUOut=0, O_DestRegIdx=0, O_Illegal=1.
REQ-018 Simultaneous handoff and accept SHALL replace the output register with the new result and keep O_Valid=1.

Reset
REQ-019 When I_RESET=1 at an edge: state=IDLE, O_Valid=0, O_Busy=0, O_Illegal=0, O_ALUOut=0, O_DestValue=0, O_DestRegIdx=0, O_Opcode=0, multiplier accumulator/counter=0.
REQ-020 Reset SHALL take priority over accept and handoff; a multiply in progress SHALL be discarded without producing output.
REQ-021 O_Ready SHALL be 0 while I_RESET=1.

Configuration
REQ-022 Macro EXECUTE_MC_MUL_EN SHALL compile in the multiplier, the MUL/DONE states and O_Busy activity.
REQ-023 Without EXECUTE_MC_MUL_EN, MUL/MULI SHALL be treated as unknown opcodes per REQ-017, O_Busy SHALL be tied to 0, and the FSM reduces to IDLE.

Structure
REQ-024 Opcode constants (OP_MUL_D, OP_MULI_D alongside the existing OP_* set), FSM state encoding and a default-width constant SHALL live in shared package exec_pkg.
REQ-025 The iterative multiplier SHALL be sub-module exec_mul_iter (start, operands, done, product), instantiated only under EXECUTE_MC_MUL_EN.

Verification
REQ-026 ADD with Src1=0x7FFF, Src2=0x0001, I_Ready=1 -> next cycle O_Valid=1, O_ALUOut=0x8000, O_DestRegIdx passed through.
REQ-027 Four back-to-back ADDI, I_Ready=1 -> four consecutive O_Valid cycles, O_Ready held 1.
REQ-028 ADD accepted, then I_Ready=0 for 3 cycles -> O_ALUOut stable, O_Ready=0, no new accept until I_Ready=1.
REQ-029 MUL Src1=0x0003, Src2=0xFFFF (REG_WIDTH=16, MUL_EN) -> O_Busy for 17 cycles, then O_ALUOut=0xFFFD.
REQ-030 I_RESET pulsed 5 cycles into a MUL -> O_Valid stays 0, O_Busy=0, next ADD completes in one cycle.
REQ-031 Opcode 0xFF -> O_Valid=1, O_Illegal=1, O_ALUOut=0; repeat for MUL without EXECUTE_MC_MUL_EN.
